aes_128_queue: RTL
==================

AES_128_QUEUE -- requirements
Module: aes_128_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries in each of the input and result FIFOs (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning the width of the occupancy counters.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports cs and we, input, 1 each, the bus select and write enable.
REQ-006 SHALL have port address, input, 8, the word address.
REQ-007 SHALL have port write_data, input, 32, the write word.
REQ-008 SHALL have port read_data, output, 32, combinational read word (0 when cs=0 or we=1).
REQ-009 SHALL have ports core_init and core_next, output, 1 each, one-cycle command pulses to AES_128_Core.
REQ-010 SHALL have ports core_encdec (1), core_key (128) and core_block (128), outputs, held stable from the command pulse until core_ready returns.
REQ-011 SHALL have ports core_ready (1), core_valid (1) and core_result (128), inputs, from the core.

Function
REQ-012 Read-only map SHALL be: 0x00 "aes ", 0x01 "    ", 0x02 VERSION 0x302e3730 ("0.70").
REQ-013 Register 0x08 CTRL (write) SHALL decode bit0=init, bit1=flush; a read SHALL return 0.
REQ-014 Register 0x09 STATUS (read) SHALL be {in_count[7:0], out_count[7:0], 10'b0, cmd_err, underflow, overflow, busy, key_ready, out_nonempty} (MSB to LSB).
REQ-015 Register 0x0a CONFIG bit0 SHALL be encdec (1=encrypt).
REQ-016 Registers 0x10-0x13 SHALL be KEY words, word0 being the MSW.
REQ-017 Registers 0x20-0x23 SHALL be block staging words; a write to 0x23 SHALL push {staging0..2, write_data} into the input FIFO in the same cycle.
REQ-018 Registers 0x30-0x33 SHALL read the result-FIFO head, word0 being the MSW; a read of 0x33 SHALL pop it, and an empty FIFO SHALL read 0.
REQ-019 FSM SHALL have states IDLE, KEY_INIT, KEY_WAIT, READY, ISSUE and WAIT.
REQ-020 On an init write in IDLE or READY, the block SHALL snapshot key to core_key, clear key_ready and go to KEY_INIT.
REQ-021 In KEY_INIT it SHALL pulse core_init for 1 cycle, then go to KEY_WAIT.
REQ-022 In KEY_WAIT, skipping the first cycle, it SHALL go to READY with key_ready=1 when core_ready=1.
REQ-023 An init write in any other state SHALL be ignored and SHALL set sticky cmd_err.
REQ-024 In READY with the input FIFO non-empty and the result FIFO not full, it SHALL pop the input head to core_block, latch encdec to core_encdec and go to ISSUE.
REQ-025 In ISSUE it SHALL pulse core_next for 1 cycle, then go to WAIT.
REQ-026 In WAIT, skipping the first cycle, on core_ready=1 it SHALL push core_result to the result FIFO and return to READY.
REQ-027 busy SHALL be 1 in every state except IDLE and READY.
REQ-028 Results SHALL leave the block in push order, with throughput limited to 1 block in flight.
REQ-029 A push while the input FIFO is full SHALL be dropped and SHALL set sticky overflow.
REQ-030 A pop while the result FIFO is empty SHALL have no effect and SHALL set sticky underflow.
REQ-031 A simultaneous push and FSM pop on the input FIFO SHALL both take effect, leaving the count unchanged.
REQ-032 A simultaneous bus pop and WAIT push on the result FIFO SHALL both take effect.
REQ-033 Flush SHALL empty both FIFOs, zero the staging words and clear the three sticky bits.
REQ-034 Flush in WAIT SHALL discard the in-flight result, go to READY, and keep key_ready.
REQ-035 Flush SHALL take priority over a same-cycle push.
REQ-036 KEY/CONFIG writes while busy SHALL update the registers only; the transaction in flight SHALL be unaffected.
REQ-037 FIFO pointers SHALL wrap modulo DEPTH, and the counts SHALL range 0..DEPTH.

Reset
REQ-038 Reset SHALL put the FSM in IDLE.
REQ-039 Reset SHALL zero the FIFOs, counts, stickies, key_ready, key, staging, config and all core_* outputs.
REQ-040 Reset mid-transaction SHALL drop all state; the core's later core_ready/core_valid SHALL then be ignored until the next init.

Structure
REQ-041 Shared package aes_128_pkg SHALL hold the address constants, name/version words, STATUS bit indices and the FSM state enum.
REQ-042 Both FIFOs SHALL be instances of one sub-module, aes_128_fifo (parameters WIDTH=128 and DEPTH), with push/pop/full/empty/count ports and a synchronous flush.

Verification
REQ-043 Key 000102..0f, init, then block 00112233445566778899aabbccddeeff with encdec=1 -> 0x30..0x33 SHALL read 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
REQ-044 Push DEPTH+1 blocks before init -> the last push SHALL be dropped with overflow=1 and in_count=DEPTH; after init, DEPTH results SHALL come out in push order.
REQ-045 Read 0x33 with the result FIFO empty -> it SHALL read 0, set underflow=1 and leave out_count=0.
REQ-046 Init write while in WAIT -> cmd_err=1, no core_init pulse, and the current result SHALL still be delivered.
REQ-047 Flush during WAIT -> the result FIFO SHALL stay empty after core_ready, in_count=0, and a following block SHALL encrypt correctly without re-init.
REQ-048 Decrypt (encdec=0) of 69c4e0d8...c55a -> the result SHALL be 00112233...ff; reset asserted mid-WAIT -> all STATUS fields SHALL read 0.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared constants for the AES-128 queued wrapper: register map, identity words,
// STATUS bit positions and the sequencing FSM state encoding.
package aes_128_pkg;

   localparam logic [7:0] ADDR_NAME0   = 8'h00;
   localparam logic [7:0] ADDR_NAME1   = 8'h01;
   localparam logic [7:0] ADDR_VERSION = 8'h02;
   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
   localparam logic [7:0] ADDR_KEY0    = 8'h10;
   localparam logic [7:0] ADDR_KEY1    = 8'h11;
   localparam logic [7:0] ADDR_KEY2    = 8'h12;
   localparam logic [7:0] ADDR_KEY3    = 8'h13;
   localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
   localparam logic [7:0] ADDR_BLOCK1  = 8'h21;
   localparam logic [7:0] ADDR_BLOCK2  = 8'h22;
   localparam logic [7:0] ADDR_BLOCK3  = 8'h23;
   localparam logic [7:0] ADDR_RESULT0 = 8'h30;
   localparam logic [7:0] ADDR_RESULT1 = 8'h31;
   localparam logic [7:0] ADDR_RESULT2 = 8'h32;
   localparam logic [7:0] ADDR_RESULT3 = 8'h33;

   localparam logic [31:0] CORE_NAME0   = 32'h61657320;
   localparam logic [31:0] CORE_NAME1   = 32'h20202020;
   localparam logic [31:0] CORE_VERSION = 32'h302e3730;

   localparam int CTRL_INIT_BIT  = 0;
   localparam int CTRL_FLUSH_BIT = 1;

   localparam int ST_OUT_NONEMPTY = 0;
   localparam int ST_KEY_READY    = 1;
   localparam int ST_BUSY         = 2;
   localparam int ST_OVERFLOW     = 3;
   localparam int ST_UNDERFLOW    = 4;
   localparam int ST_CMD_ERR      = 5;
   localparam int ST_OUT_COUNT_LSB = 16;
   localparam int ST_IN_COUNT_LSB  = 24;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_KEY_INIT = 3'd1,
      ST_KEY_WAIT = 3'd2,
      ST_READY    = 3'd3,
      ST_ISSUE    = 3'd4,
      ST_WAIT     = 3'd5
   } state_t;

   // Word 0 is the most significant 32 bits of a 128-bit block.
   function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
      logic [31:0] w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/aes_128_fifo.sv
// Circular FIFO with head-of-queue output, occupancy count and synchronous flush.
// A push while full or a pop while empty is ignored; flush wins over both.
module aes_128_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/aes_128_queue.sv
// Bus-mapped AES-128 wrapper: queues plaintext blocks, sequences an external
// AES_128_Core one block at a time and queues the results for readback.
//
// state    | meaning
// IDLE     | no key loaded; waiting for an init command
// KEY_INIT | core_init pulse being issued with the snapshotted key
// KEY_WAIT | key expansion running in the core
// READY    | key loaded; issue the next queued block when possible
// ISSUE    | core_next pulse being issued for the popped block
// WAIT     | block in flight; capture core_result on core_ready
module aes_128_queue
   import aes_128_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cs,
   input  logic         we,
   input  logic [7:0]   address,
   input  logic [31:0]  write_data,
   output logic [31:0]  read_data,
   output logic         core_init,
   output logic         core_next,
   output logic         core_encdec,
   output logic [127:0] core_key,
   output logic [127:0] core_block,
   input  logic         core_ready,
   input  logic         core_valid,
   input  logic [127:0] core_result
);

   state_t           state;
   logic             wr_en;
   logic             rd_en;
   logic             init_cmd;
   logic             flush_cmd;
   logic             in_push;
   logic             in_pop;
   logic             out_push;
   logic             out_pop;
   logic [127:0]     in_head;
   logic [127:0]     out_head;
   logic             in_full;
   logic             in_empty;
   logic             out_full;
   logic             out_empty;
   logic [CNT_W-1:0] in_count;
   logic [CNT_W-1:0] out_count;
   logic [31:0]      key_word [4];
   logic [31:0]      staging [3];
   logic             encdec_cfg;
   logic             cmd_err;
   logic             underflow;
   logic             overflow;
   logic             key_ready;
   logic             busy;
   logic             unused_core_valid;

   // Completion is signalled by core_ready alone; core_valid carries no extra information here.
   assign unused_core_valid = core_valid;

   assign wr_en     = cs && we;
   assign rd_en     = cs && !we;
   assign init_cmd  = wr_en && (address == ADDR_CTRL) && write_data[CTRL_INIT_BIT];
   assign flush_cmd = wr_en && (address == ADDR_CTRL) && write_data[CTRL_FLUSH_BIT];
   assign in_push   = wr_en && (address == ADDR_BLOCK3);
   assign out_pop   = rd_en && (address == ADDR_RESULT3);
   assign busy      = !((state == ST_IDLE) || (state == ST_READY));

   // core_ready gating keeps a new block from being issued while a block
   // abandoned by a flush is still being processed by the core.
   assign in_pop = (state == ST_READY) && !init_cmd && !flush_cmd && !in_empty
                   && !out_full && core_ready;

   // core_next still high marks the first WAIT cycle, where core_ready is stale.
   assign out_push = (state == ST_WAIT) && !core_next && core_ready && !flush_cmd;

   aes_128_fifo #(.WIDTH(128), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_cmd),
      .push      (in_push),
      .push_data ({staging[0], staging[1], staging[2], write_data}),
      .pop       (in_pop),
      .head      (in_head),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_count)
   );

   aes_128_fifo #(.WIDTH(128), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_cmd),
      .push      (out_push),
      .push_data (core_result),
      .pop       (out_pop),
      .head      (out_head),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) key_word[i] <= '0;
         for (int i = 0; i < 3; i++) staging[i] <= '0;
         encdec_cfg <= 1'b0;
         cmd_err    <= 1'b0;
         underflow  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (flush_cmd) begin
            for (int i = 0; i < 3; i++) staging[i] <= '0;
            cmd_err   <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            if (in_push && in_full)   overflow  <= 1'b1;
            if (out_pop && out_empty) underflow <= 1'b1;
            if (init_cmd && busy)     cmd_err   <= 1'b1;
         end
         if (wr_en) begin
            case (address)
               ADDR_CONFIG: encdec_cfg <= write_data[0];
               ADDR_KEY0, ADDR_KEY1, ADDR_KEY2, ADDR_KEY3:
                  key_word[address[1:0]] <= write_data;
               ADDR_BLOCK0, ADDR_BLOCK1, ADDR_BLOCK2:
                  staging[address[1:0]] <= write_data;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         key_ready   <= 1'b0;
         core_init   <= 1'b0;
         core_next   <= 1'b0;
         core_encdec <= 1'b0;
         core_key    <= '0;
         core_block  <= '0;
      end else begin
         core_init <= 1'b0;
         core_next <= 1'b0;
         case (state)
            ST_IDLE, ST_READY: begin
               if (init_cmd) begin
                  core_key  <= {key_word[0], key_word[1], key_word[2], key_word[3]};
                  key_ready <= 1'b0;
                  state     <= ST_KEY_INIT;
               end else if (in_pop) begin
                  core_block  <= in_head;
                  core_encdec <= encdec_cfg;
                  state       <= ST_ISSUE;
               end
            end
            ST_KEY_INIT: begin
               core_init <= 1'b1;
               state     <= ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
               if (!core_init && core_ready) begin
                  key_ready <= 1'b1;
                  state     <= ST_READY;
               end
            end
            ST_ISSUE: begin
               if (flush_cmd) begin
                  state <= ST_READY;
               end else begin
                  core_next <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (flush_cmd || out_push) state <= ST_READY;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      read_data = '0;
      if (rd_en) begin
         case (address)
            ADDR_NAME0:   read_data = CORE_NAME0;
            ADDR_NAME1:   read_data = CORE_NAME1;
            ADDR_VERSION: read_data = CORE_VERSION;
            ADDR_STATUS:  read_data = {8'(in_count), 8'(out_count), 10'b0, cmd_err,
                                       underflow, overflow, busy, key_ready, !out_empty};
            ADDR_CONFIG:  read_data = {31'b0, encdec_cfg};
            ADDR_KEY0, ADDR_KEY1, ADDR_KEY2, ADDR_KEY3:
               read_data = key_word[address[1:0]];
            ADDR_BLOCK0, ADDR_BLOCK1, ADDR_BLOCK2:
               read_data = staging[address[1:0]];
            ADDR_RESULT0, ADDR_RESULT1, ADDR_RESULT2, ADDR_RESULT3:
               if (!out_empty) read_data = block_word(out_head, address[1:0]);
            default: read_data = '0;
         endcase
      end
   end

endmodule
